// File: rtl/pingpong_rd_sched_pkg.sv
// Shared constants for the ping-pong packet buffer: geometry, packet sizes
// and the read scheduler's state encoding.
package pingpong_rd_sched_pkg;

  localparam int LINE_BYTES    = 1392;
  localparam int IMG_HEIGHT    = 1024;

  localparam int RD_WORDS_DEF  = 352;
  localparam int CMD_WORDS_DEF = 4;
  localparam int HEIGHT_DEF    = IMG_HEIGHT;
  localparam int AW_DEF        = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_PIX_RD = 2'd1;
  localparam state_t ST_CMD_RD = 2'd2;
  localparam state_t ST_FLUSH  = 2'd3;

endpackage

// File: rtl/pingpong_rd_sched_bank_tracker.sv
// Watches the ingress write strobe and keeps per-bank full/type bits plus
// the sticky overrun flag.
module pp_bank_tracker (
  input  logic       RFCLK,
  input  logic       nRST_Pixel,
  input  logic       wrreq,
  input  logic       wr_bank,
  input  logic       mode_set,
  input  logic       frame_sync,
  input  logic       clr_en,
  input  logic       clr_bank,
  output logic [1:0] bank_full,
  output logic [1:0] bank_type,
  output logic       overflow
);

  logic wrreq_d;
  logic wb;
  logic mode_d;
  logic wr_rise;
  logic wr_fall;

  assign wr_rise = wrreq & ~wrreq_d;
  assign wr_fall = ~wrreq & wrreq_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; where two assignments hit the same bit, the later
  // statement wins, which is how set-over-clear and overrun-over-sync are built.
  always_ff @(posedge RFCLK or negedge nRST_Pixel) begin
    if (!nRST_Pixel) begin
      wrreq_d   <= 1'b0;
      wb        <= 1'b0;
      mode_d    <= 1'b0;
      bank_full <= 2'b00;
      bank_type <= 2'b00;
      overflow  <= 1'b0;
    end else begin
      wrreq_d <= wrreq;
      if (wrreq)
        mode_d <= mode_set;
      if (wr_rise)
        wb <= wr_bank;

      if (frame_sync)
        overflow <= 1'b0;
      if (wr_rise && bank_full[wr_bank])
        overflow <= 1'b1;

      if (clr_en)
        bank_full[clr_bank] <= 1'b0;
      if (wr_fall) begin
        bank_full[wb] <= 1'b1;
        bank_type[wb] <= mode_d;
      end
    end
  end

endmodule

// File: rtl/pingpong_rd_sched.sv
// Read-side scheduler for the 2-bank ping-pong buffer: drains complete banks
// in arrival order, steers beats to pixel/command sinks and counts lines.
module pingpong_rd_sched
  import pingpong_rd_sched_pkg::*;
#(
  parameter int RD_WORDS  = RD_WORDS_DEF,
  parameter int CMD_WORDS = CMD_WORDS_DEF,
  parameter int HEIGHT    = HEIGHT_DEF,
  parameter int AW        = AW_DEF
) (
  input  logic          RFCLK,
  input  logic          nRST_Pixel,
  input  logic          wrreq,
  input  logic          wr_bank,
  input  logic          mode_set,
  input  logic          frame_sync,
  output logic [AW-1:0] rdaddr,
  output logic          rden,
  input  logic          pix_ready,
  output logic          pix_valid,
  output logic          pix_last,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic          cmd_last,
  output logic [1:0]    bank_full,
  output logic [10:0]   line_cnt,
  output logic          frame_done,
  output logic          frame_err,
  output logic          overflow
);

  state_t        state;
  logic          rd_bank;
  logic          cur_cmd;
  logic [AW-2:0] cnt;
  logic [1:0]    bank_type;
  logic          last_word;
  logic          pix_issue;
  logic          cmd_issue;
  logic          flush;
  logic          pix_flush;
  logic          height_hit;

  pp_bank_tracker u_tracker (
    .RFCLK      (RFCLK),
    .nRST_Pixel (nRST_Pixel),
    .wrreq      (wrreq),
    .wr_bank    (wr_bank),
    .mode_set   (mode_set),
    .frame_sync (frame_sync),
    .clr_en     (flush),
    .clr_bank   (rd_bank),
    .bank_full  (bank_full),
    .bank_type  (bank_type),
    .overflow   (overflow)
  );

  assign pix_issue = (state == ST_PIX_RD) & pix_ready;
  assign cmd_issue = (state == ST_CMD_RD) & cmd_ready;
  assign rden      = pix_issue | cmd_issue;
  assign rdaddr    = {rd_bank, cnt};
  assign flush     = (state == ST_FLUSH);
  assign pix_flush = flush & ~cur_cmd;
  assign height_hit = pix_flush & (line_cnt == 11'(HEIGHT - 1));

  always_comb begin
    last_word = 1'b0;
    if (state == ST_PIX_RD)
      last_word = (cnt == (AW-1)'(RD_WORDS - 1));
    else if (state == ST_CMD_RD)
      last_word = (cnt == (AW-1)'(CMD_WORDS - 1));
  end

  always_ff @(posedge RFCLK or negedge nRST_Pixel) begin
    if (!nRST_Pixel) begin
      state   <= ST_IDLE;
      rd_bank <= 1'b0;
      cur_cmd <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bank_full[rd_bank]) begin
            cnt     <= '0;
            cur_cmd <= bank_type[rd_bank];
            state   <= bank_type[rd_bank] ? ST_CMD_RD : ST_PIX_RD;
          end
        end
        ST_PIX_RD, ST_CMD_RD: begin
          if (rden) begin
            cnt <= cnt + 1'b1;
            if (last_word)
              state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          rd_bank <= ~rd_bank;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM data trails rden by one cycle, so valid/last are issue strobes delayed to match.
  always_ff @(posedge RFCLK or negedge nRST_Pixel) begin
    if (!nRST_Pixel) begin
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_last  <= 1'b0;
    end else begin
      pix_valid <= pix_issue;
      pix_last  <= pix_issue & last_word;
      cmd_valid <= cmd_issue;
      cmd_last  <= cmd_issue & last_word;
    end
  end

  // A sync landing on the HEIGHT-th flush completes the frame rather than truncating it.
  always_ff @(posedge RFCLK or negedge nRST_Pixel) begin
    if (!nRST_Pixel) begin
      line_cnt   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (height_hit) begin
        line_cnt   <= '0;
        frame_done <= 1'b1;
      end else if (pix_flush) begin
        line_cnt <= line_cnt + 1'b1;
      end
      if (frame_sync) begin
        line_cnt <= '0;
        if (!height_hit && line_cnt != '0 && line_cnt < 11'(HEIGHT))
          frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_rd_sched.sv
// Directed bench for pingpong_rd_sched: single/command packets, backpressure,
// overrun, frame accounting (HEIGHT shortened to 8) and reset mid-drain.
module tb_pingpong_rd_sched;

  localparam int HT = 8;

  logic        RFCLK = 1'b0;
  logic        nRST_Pixel;
  logic        wrreq, wr_bank, mode_set, frame_sync;
  logic        pix_ready, cmd_ready;
  logic [9:0]  rdaddr;
  logic        rden, pix_valid, pix_last, cmd_valid, cmd_last;
  logic [1:0]  bank_full;
  logic [10:0] line_cnt;
  logic        frame_done, frame_err, overflow;

  int checks   = 0;
  int failures = 0;

  // sampled-beat bookkeeping, updated on falling edges inside tick()
  int n_rd, n_pix, n_pix_last, pix_last_at, n_cmd, n_cmd_last, cmd_last_at;
  int n_done, n_err, addr_bad;
  logic [9:0] exp_addr;
  logic nb;
  int cyc;

  pingpong_rd_sched #(.HEIGHT(HT)) dut (
    .RFCLK      (RFCLK),
    .nRST_Pixel (nRST_Pixel),
    .wrreq      (wrreq),
    .wr_bank    (wr_bank),
    .mode_set   (mode_set),
    .frame_sync (frame_sync),
    .rdaddr     (rdaddr),
    .rden       (rden),
    .pix_ready  (pix_ready),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_last   (cmd_last),
    .bank_full  (bank_full),
    .line_cnt   (line_cnt),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 RFCLK = ~RFCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input logic [9:0] base);
    n_rd = 0; n_pix = 0; n_pix_last = 0; pix_last_at = 0;
    n_cmd = 0; n_cmd_last = 0; cmd_last_at = 0;
    n_done = 0; n_err = 0; addr_bad = 0; exp_addr = base;
  endtask

  task automatic tick();
    @(negedge RFCLK);
    if (rden) begin
      if (rdaddr !== exp_addr) addr_bad++;
      exp_addr = exp_addr + 10'd1;
      n_rd++;
    end
    if (pix_valid) begin
      n_pix++;
      if (pix_last) begin n_pix_last++; pix_last_at = n_pix; end
    end
    if (cmd_valid) begin
      n_cmd++;
      if (cmd_last) begin n_cmd_last++; cmd_last_at = n_cmd; end
    end
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
    @(posedge RFCLK);
    #1;
  endtask

  task automatic write_pkt(input logic b, input logic m, input int len);
    wr_bank = b; mode_set = m; wrreq = 1'b1;
    repeat (len) tick();
    wrreq = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input logic toggle, output int cycles);
    cycles = 0;
    while (bank_full != 2'b00 && cycles < 3000) begin
      if (toggle) pix_ready = ~pix_ready;
      tick();
      cycles++;
    end
    if (cycles >= 3000) check("drain_timeout", 32'd1, 32'd0);
    tick();
    tick();
  endtask

  task automatic run_pix();
    write_pkt(nb, 1'b0, 2);
    wait_idle(1'b0, cyc);
    nb = ~nb;
  endtask

  initial begin
    nRST_Pixel = 1'b0;
    wrreq = 1'b0; wr_bank = 1'b0; mode_set = 1'b0; frame_sync = 1'b0;
    pix_ready = 1'b0; cmd_ready = 1'b0;
    nb = 1'b0;
    clear_mon(10'd0);
    repeat (3) tick();
    check("rst_rden", {31'd0, rden}, 32'd0);
    check("rst_bank_full", {30'd0, bank_full}, 32'd0);
    check("rst_line_cnt", {21'd0, line_cnt}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_rdaddr", {22'd0, rdaddr}, 32'd0);
    nRST_Pixel = 1'b1;
    tick();

    // single full-length pixel packet on bank 0
    pix_ready = 1'b1; cmd_ready = 1'b1;
    clear_mon(10'd0);
    write_pkt(1'b0, 1'b0, 352);
    check("pix1_full", {30'd0, bank_full}, 32'd1);
    wait_idle(1'b0, cyc);
    nb = 1'b1;
    check("pix1_rd", n_rd, 352);
    check("pix1_beats", n_pix, 352);
    check("pix1_last_cnt", n_pix_last, 1);
    check("pix1_last_at", pix_last_at, 352);
    check("pix1_addr", addr_bad, 0);
    check("pix1_no_cmd", n_cmd, 0);
    check("pix1_line", {21'd0, line_cnt}, 32'd1);
    check("pix1_empty", {30'd0, bank_full}, 32'd0);

    // command packet on bank 1
    clear_mon(10'd512);
    write_pkt(1'b1, 1'b1, 4);
    wait_idle(1'b0, cyc);
    nb = 1'b0;
    check("cmd_beats", n_cmd, 4);
    check("cmd_last_at", cmd_last_at, 4);
    check("cmd_addr", addr_bad, 0);
    check("cmd_no_pix", n_pix, 0);
    check("cmd_line", {21'd0, line_cnt}, 32'd1);

    // pix_ready toggling every cycle
    clear_mon(10'd0);
    write_pkt(1'b0, 1'b0, 8);
    wait_idle(1'b1, cyc);
    pix_ready = 1'b1;
    nb = 1'b1;
    check("bp_beats", n_pix, 352);
    check("bp_rd", n_rd, 352);
    check("bp_addr", addr_bad, 0);
    check("bp_cycles", {31'd0, (cyc >= 700 && cyc <= 712)}, 32'd1);
    check("bp_line", {21'd0, line_cnt}, 32'd2);

    // overrun: both banks full, third write re-targets bank 0
    pix_ready = 1'b0; cmd_ready = 1'b0;
    clear_mon(10'd512);
    write_pkt(1'b1, 1'b0, 4);
    write_pkt(1'b0, 1'b0, 4);
    check("ovr_both_full", {30'd0, bank_full}, 32'd3);
    check("ovr_pre", {31'd0, overflow}, 32'd0);
    wr_bank = 1'b0; mode_set = 1'b0; wrreq = 1'b1;
    tick();
    check("ovr_set", {31'd0, overflow}, 32'd1);
    repeat (3) tick();
    wrreq = 1'b0;
    repeat (2) tick();
    check("ovr_hold", {31'd0, overflow}, 32'd1);
    pix_ready = 1'b1;
    wait_idle(1'b0, cyc);
    check("ovr_beats", n_pix, 704);
    check("ovr_line", {21'd0, line_cnt}, 32'd4);
    check("ovr_sticky", {31'd0, overflow}, 32'd1);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("short_err", {31'd0, frame_err}, 32'd1);
    check("short_line", {21'd0, line_cnt}, 32'd0);
    check("ovr_cleared", {31'd0, overflow}, 32'd0);
    tick();
    check("short_err_pulse", {31'd0, frame_err}, 32'd0);

    // frame A: frame_sync coincides with the HEIGHT-th flush
    clear_mon(10'd0);
    for (int i = 0; i < HT - 1; i++) run_pix();
    check("fa_line7", {21'd0, line_cnt}, 32'd7);
    check("fa_no_done", n_done, 0);
    write_pkt(nb, 1'b0, 2);
    cyc = 0;
    while (!pix_last && cyc < 1000) begin tick(); cyc++; end
    if (cyc >= 1000) check("fa_last_timeout", 32'd1, 32'd0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    nb = ~nb;
    check("fa_done", {31'd0, frame_done}, 32'd1);
    check("fa_no_err", {31'd0, frame_err}, 32'd0);
    check("fa_line0", {21'd0, line_cnt}, 32'd0);
    repeat (2) tick();
    check("fa_done_cnt", n_done, 1);
    check("fa_err_cnt", n_err, 0);

    // frame B: full frame then a clean frame_sync
    clear_mon(10'd0);
    for (int i = 0; i < HT; i++) run_pix();
    check("fb_done_cnt", n_done, 1);
    check("fb_line0", {21'd0, line_cnt}, 32'd0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    check("fb_no_err", {31'd0, frame_err}, 32'd0);
    check("fb_err_cnt", n_err, 0);

    // reset at word 100 of a drain on bank 1
    clear_mon(10'd512);
    write_pkt(nb, 1'b0, 2);
    cyc = 0;
    while (n_rd < 100 && cyc < 1000) begin tick(); cyc++; end
    check("rm_pre_rden", {31'd0, rden}, 32'd1);
    check("rm_addr", addr_bad, 0);
    #2;
    nRST_Pixel = 1'b0;
    #1;
    check("rm_rden", {31'd0, rden}, 32'd0);
    check("rm_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rm_bank_full", {30'd0, bank_full}, 32'd0);
    tick();
    nRST_Pixel = 1'b1;
    tick();
    check("rm_rdaddr", {22'd0, rdaddr}, 32'd0);
    check("rm_line", {21'd0, line_cnt}, 32'd0);
    clear_mon(10'd0);
    write_pkt(1'b0, 1'b0, 2);
    wait_idle(1'b0, cyc);
    check("rm_post_beats", n_pix, 352);
    check("rm_post_addr", addr_bad, 0);
    check("rm_post_line", {21'd0, line_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pingpong_rd_sched.md
Name: pingpong_rd_sched

Overview:
- Read-side scheduler for the 2x512-word ping-pong packet buffer filled by the ingress state machine.
- Tracks which bank holds a complete packet and drains banks in arrival order.
- Routes pixel packets (MODE_SET=0) to the pixel sink and command packets (MODE_SET=1) to the command sink.
- Counts lines per frame, and flags bank overruns and short frames.

Parameters:
- RD_WORDS, 352: 32-bit words read per pixel packet (1392 B + 16 B header tail / 4).
- CMD_WORDS, 4: words read per command packet.
- HEIGHT, 1024: pixel packets (lines) per frame.
- AW, 10: buffer address width; MSB selects the bank.

Ports:
- RFCLK  in  1  clock.
- nRST_Pixel  in  1  reset.
- wrreq  in  1  ingress write request; high for the whole payload of a packet.
- wr_bank  in  1  ingress wraddr[AW-1].
- mode_set  in  1  ingress MODE_SET; stable while wrreq=1.
- frame_sync  in  1  one-cycle start-of-frame pulse.
- rdaddr  out  AW  buffer read address.
- rden  out  1  buffer read enable; RAM returns data 1 cycle later.
- pix_ready  in  1  pixel sink issue permit.
- pix_valid  out  1  pixel beat valid (rden delayed 1, pixel packet).
- pix_last  out  1  final beat of a pixel packet.
- cmd_ready  in  1  command sink issue permit.
- cmd_valid  out  1  command beat valid.
- cmd_last  out  1  final beat of a command packet.
- bank_full  out  2  per-bank complete-and-unread flag.
- line_cnt  out  11  lines read in the current frame.
- frame_done  out  1  one-cycle pulse after line HEIGHT is read.
- frame_err  out  1  one-cycle pulse when frame_sync arrives with 0 < line_cnt < HEIGHT.
- overflow  out  1  sticky overrun flag; cleared by frame_sync.

Behaviour:
- Reset: nRST_Pixel is asynchronous and active-low; the block is clocked on RFCLK. While in reset all outputs are 0, state=IDLE, rd_bank=0, the type bits are cleared, and any in-progress read is abandoned.
- Write tracking:
  - wrreq is registered to wrreq_d.
  - Rising edge (wrreq=1, wrreq_d=0): capture wb=wr_bank. If bank_full[wb]=1, set overflow=1.
  - Falling edge: set bank_full[wb]=1 and type[wb]=mode_set, with mode_set sampled during the last wrreq=1 cycle.
- Drain order: rd_bank starts at 0 and toggles after each completed drain. A drain only starts when bank_full[rd_bank]=1, so packets are strictly FIFO.
- FSM states: IDLE, PIX_RD, CMD_RD, FLUSH.
  - IDLE: if bank_full[rd_bank], load word counter=0 and go to PIX_RD if type=0, else CMD_RD.
  - PIX_RD / CMD_RD: rden = pix_ready / cmd_ready (combinational). rdaddr = {rd_bank, counter}. The counter increments on each rden. When rden issues the final word (counter = RD_WORDS-1 / CMD_WORDS-1), go to FLUSH.
  - FLUSH: one cycle for the last data beat. Clear bank_full[rd_bank], toggle rd_bank, return to IDLE.
- Sink interface: the valid output = rden delayed 1 cycle and steered by the packet type; *_last is delayed the same way. A sink must accept every valid beat. ready only gates issue, so it may drop at any cycle with no data loss.
- Simultaneous fill and clear of the same bank is impossible by construction. If a falling edge and a FLUSH target the same bank in the same cycle, set wins.
- Line accounting:
  - line_cnt increments in FLUSH for pixel packets only.
  - When the increment reaches HEIGHT: pulse frame_done and load line_cnt=0.
  - frame_sync: line_cnt=0 and overflow=0. Pulse frame_err if the pre-sync line_cnt was in 1..HEIGHT-1.
  - frame_sync in the same cycle as the HEIGHT-th FLUSH: frame_done pulses, frame_err does not, line_cnt=0.
- Overrun data is not dropped: the overwritten bank is drained normally with the new contents.
- Throughput: with ready held high, one pixel packet takes RD_WORDS+2 cycles from IDLE to IDLE.

Decomposition:
- Shared package: FSM state encoding, RD_WORDS/CMD_WORDS/HEIGHT defaults, and the Width/Height constants also used by ingress.
- One natural sub-module, pp_bank_tracker: edge detect, bank_full/type bits and overflow. The FSM and line counter stay in the top.

Test Plan:
- Single pixel packet:
  - Stimulus: wrreq high 352 cycles on bank 0 with mode_set=0, ready=1.
  - Response: bank_full=01. Then rdaddr runs 0..351 with 352 pix_valid beats, pix_last on the 352nd. bank_full returns to 00 and line_cnt=1.
- Command packet:
  - Stimulus: bank 1 filled with mode_set=1.
  - Response: 4 cmd_valid beats at rdaddr 512..515, cmd_last on beat 4, no pix_valid, line_cnt unchanged.
- Backpressure:
  - Stimulus: pix_ready toggles 1/0 every cycle.
  - Response: 352 beats over about 704 cycles, addresses contiguous, no beat lost or duplicated.
- Overrun:
  - Stimulus: fill bank 0 and bank 1 with pix_ready=0, then start a third write to bank 0.
  - Response: overflow=1 at the rising edge, held until the next frame_sync.
- Frame boundary:
  - Stimulus: 1024 packets, then frame_sync.
  - Response: frame_done pulses once after the 1024th FLUSH, line_cnt=0, no frame_err. A frame_sync after 500 lines gives frame_err=1 and line_cnt=0.
- Reset mid-drain:
  - Stimulus: nRST_Pixel low at word 100 of a drain.
  - Response: rden, pix_valid and bank_full drop asynchronously. After release, rd_bank=0 and the FSM is in IDLE.
